// File: rtl/gnr_attractor_ctrl_if.sv
// Host/config and node-array signals of the attractor controller, grouped as one bundle.
// slave is the controller's view; master is the host plus node array.
interface gnr_attractor_ctrl_if #(
    parameter int unsigned N_NODES = 8,
    parameter int unsigned STEP_W  = 16
);
    logic               start;
    logic [N_NODES-1:0] init_vec;
    logic [N_NODES-1:0] lat_s0;
    logic [N_NODES-1:0] lat_s1;
    logic               reset_nos;
    logic               start_s0;
    logic               start_s1;
    logic [N_NODES-1:0] init_state;
    logic               busy;
    logic               done;
    logic               found;
    logic               timeout;
    logic [STEP_W-1:0]  meet_step;
    logic [STEP_W-1:0]  period;

    modport slave (
        input  start, init_vec, lat_s0, lat_s1,
        output reset_nos, start_s0, start_s1, init_state,
        output busy, done, found, timeout, meet_step, period
    );

    modport master (
        output start, init_vec, lat_s0, lat_s1,
        input  reset_nos, start_s0, start_s1, init_state,
        input  busy, done, found, timeout, meet_step, period
    );
endinterface

// File: rtl/gnr_attractor_ctrl.sv
// Floyd tortoise/hare sequencer for a dual-state gene-network node array.
// Finds the meeting step, then measures the attractor period with the fast copy alone.
module gnr_attractor_ctrl #(
    parameter int unsigned N_NODES   = 8,
    parameter int unsigned STEP_W    = 16,
    parameter int unsigned MAX_STEPS = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    gnr_attractor_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        StIdle, StLoad, StRunA, StRunB, StCheck, StPerStep, StPerChk, StDone
    } state_e;

    localparam logic [STEP_W-1:0] MaxQ = STEP_W'(MAX_STEPS);
    localparam logic [STEP_W-1:0] OneQ = STEP_W'(1);

    state_e             r_state;
    logic [N_NODES-1:0] r_init_state;
    logic               r_reset_nos;
    logic               r_start_s0;
    logic               r_start_s1;
    logic               r_busy;
    logic               r_done;
    logic               r_found;
    logic               r_timeout;
    logic [STEP_W-1:0]  r_meet_step;
    logic [STEP_W-1:0]  r_period;
    logic               w_match;

    assign w_match = (bus.lat_s0 == bus.lat_s1);

    // Strobes are registered alongside the state so each one equals a decode of the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_init_state <= '0;
            r_reset_nos  <= 1'b0;
            r_start_s0   <= 1'b0;
            r_start_s1   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_found      <= 1'b0;
            r_timeout    <= 1'b0;
            r_meet_step  <= '0;
            r_period     <= '0;
        end else begin
            r_reset_nos <= 1'b0;
            r_start_s0  <= 1'b0;
            r_start_s1  <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_init_state <= bus.init_vec;
                        r_found      <= 1'b0;
                        r_timeout    <= 1'b0;
                        r_meet_step  <= '0;
                        r_period     <= '0;
                        r_busy       <= 1'b1;
                        r_reset_nos  <= 1'b1;
                        r_state      <= StLoad;
                    end
                end
                StLoad: begin
                    r_start_s0 <= 1'b1;
                    r_start_s1 <= 1'b1;
                    r_state    <= StRunA;
                end
                StRunA: begin
                    r_start_s0 <= 1'b1;
                    r_start_s1 <= 1'b1;
                    r_state    <= StRunB;
                end
                StRunB: begin
                    if (r_meet_step != MaxQ) begin
                        r_meet_step <= r_meet_step + OneQ;
                    end
                    r_state <= StCheck;
                end
                StCheck: begin
                    if (w_match) begin
                        r_start_s1 <= 1'b1;
                        r_state    <= StPerStep;
                    end else if (r_meet_step == MaxQ) begin
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= StDone;
                    end else begin
                        r_start_s0 <= 1'b1;
                        r_start_s1 <= 1'b1;
                        r_state    <= StRunA;
                    end
                end
                StPerStep: begin
                    if (r_period != MaxQ) begin
                        r_period <= r_period + OneQ;
                    end
                    r_state <= StPerChk;
                end
                StPerChk: begin
                    if (w_match) begin
                        r_found <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else if (r_period == MaxQ) begin
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= StDone;
                    end else begin
                        r_start_s1 <= 1'b1;
                        r_state    <= StPerStep;
                    end
                end
                StDone: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.reset_nos  = r_reset_nos;
    assign bus.start_s0   = r_start_s0;
    assign bus.start_s1   = r_start_s1;
    assign bus.init_state = r_init_state;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.found      = r_found;
    assign bus.timeout    = r_timeout;
    assign bus.meet_step  = r_meet_step;
    assign bus.period     = r_period;
endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Directed bench for gnr_attractor_ctrl with behavioural dual-state node arrays.
// Instance A uses MAX_STEPS=1000, instance B uses MAX_STEPS=5 for the timeout case.
module tb_gnr_attractor_ctrl;
    localparam int unsigned N = 8;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gnr_attractor_ctrl_if #(.N_NODES(N), .STEP_W(W)) ifa ();
    gnr_attractor_ctrl_if #(.N_NODES(N), .STEP_W(W)) ifb ();

    gnr_attractor_ctrl #(.N_NODES(N), .STEP_W(W), .MAX_STEPS(1000)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );
    gnr_attractor_ctrl #(.N_NODES(N), .STEP_W(W), .MAX_STEPS(5)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int mode_a   = 0;
    int mode_b   = 0;
    logic sel    = 1'b0;

    // Mode 0: fixed point. Mode 1: 10->11->12->13->14->12. Mode 2: 0..9 transient, 10..73 cycle.
    function automatic logic [7:0] nxt(input int mode, input logic [7:0] s);
        if (mode == 1) begin
            case (s)
                8'h10:   return 8'h11;
                8'h11:   return 8'h12;
                8'h12:   return 8'h13;
                8'h13:   return 8'h14;
                8'h14:   return 8'h12;
                default: return s;
            endcase
        end else if (mode == 2) begin
            return (s >= 8'd73) ? 8'd10 : s + 8'd1;
        end
        return s;
    endfunction

    logic [N-1:0] a_s0 = '0, a_s1 = '0, b_s0 = '0, b_s1 = '0;
    logic         a_par = 1'b0, b_par = 1'b0;

    always @(posedge clk) begin
        if (ifa.reset_nos) begin
            a_s0 <= ifa.init_state; a_s1 <= ifa.init_state; a_par <= 1'b0;
        end else begin
            if (ifa.start_s1) a_s1 <= nxt(mode_a, a_s1);
            if (ifa.start_s0) begin
                a_par <= ~a_par;
                if (a_par) a_s0 <= nxt(mode_a, a_s0);
            end
        end
    end

    always @(posedge clk) begin
        if (ifb.reset_nos) begin
            b_s0 <= ifb.init_state; b_s1 <= ifb.init_state; b_par <= 1'b0;
        end else begin
            if (ifb.start_s1) b_s1 <= nxt(mode_b, b_s1);
            if (ifb.start_s0) begin
                b_par <= ~b_par;
                if (b_par) b_s0 <= nxt(mode_b, b_s0);
            end
        end
    end

    assign ifa.lat_s0 = a_s0;
    assign ifa.lat_s1 = a_s1;
    assign ifb.lat_s0 = b_s0;
    assign ifb.lat_s1 = b_s1;

    wire         m_busy       = sel ? ifb.busy      : ifa.busy;
    wire         m_done       = sel ? ifb.done      : ifa.done;
    wire         m_found      = sel ? ifb.found     : ifa.found;
    wire         m_timeout    = sel ? ifb.timeout   : ifa.timeout;
    wire         m_reset_nos  = sel ? ifb.reset_nos : ifa.reset_nos;
    wire         m_s0         = sel ? ifb.start_s0  : ifa.start_s0;
    wire         m_s1         = sel ? ifb.start_s1  : ifa.start_s1;
    wire [N-1:0] m_init_state = sel ? ifb.init_state : ifa.init_state;
    wire [W-1:0] m_meet       = sel ? ifb.meet_step : ifa.meet_step;
    wire [W-1:0] m_period     = sel ? ifb.period    : ifa.period;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_start(input logic [7:0] iv);
        if (sel) begin ifb.init_vec = iv; ifb.start = 1'b1; end
        else     begin ifa.init_vec = iv; ifa.start = 1'b1; end
    endtask

    task automatic drop_start();
        ifa.start = 1'b0;
        ifb.start = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"}, m_busy, 0);
        chk({tag, "_done"}, m_done, 0);
        chk({tag, "_strobes"}, {m_reset_nos, m_s0, m_s1}, 0);
        chk({tag, "_results"}, {m_found, m_timeout}, 0);
        chk({tag, "_meet"}, m_meet, 0);
        chk({tag, "_period"}, m_period, 0);
        chk({tag, "_init_state"}, m_init_state, 0);
    endtask

    // flags[0]: extra start mid-run; flags[1]: extra start in the done cycle.
    task automatic run(input logic [7:0] iv, input int e_found, input int e_to,
                       input int e_meet, input int e_per, input int e_len, input int flags);
        int cyc, s0run, nrn, ns0, ns1;
        @(negedge clk);
        drive_start(iv);
        @(negedge clk);
        drop_start();
        cyc = 1;
        chk("load_reset_nos", m_reset_nos, 1);
        chk("busy_set", m_busy, 1);
        chk("init_latched", m_init_state, iv);
        chk("results_cleared", {m_found, m_timeout}, 0);
        nrn = 0; ns0 = 0; ns1 = 0; s0run = 0;
        while (!m_done && cyc < 400) begin
            nrn += int'(m_reset_nos);
            ns0 += int'(m_s0);
            ns1 += int'(m_s1);
            if (m_s0) begin
                s0run++;
            end else if (s0run != 0) begin
                chk("s0_paired", s0run, 2);
                s0run = 0;
            end
            if (flags[0] && cyc == 3) drive_start(~iv);
            if (flags[0] && cyc == 4) drop_start();
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", m_done, 1);
        chk("run_len", cyc, e_len);
        chk("found", m_found, e_found);
        chk("timeout", m_timeout, e_to);
        chk("meet_step", m_meet, e_meet);
        chk("period", m_period, e_per);
        chk("busy_in_done", m_busy, 1);
        chk("reset_nos_count", nrn, 1);
        chk("s0_count", ns0, 2 * e_meet);
        chk("s1_count", ns1, 2 * e_meet + e_per);
        chk("init_kept", m_init_state, iv);
        if (flags[1]) drive_start(iv ^ 8'h3C);
        @(negedge clk);
        drop_start();
        chk("idle_busy", m_busy, 0);
        chk("done_pulse", m_done, 0);
        chk("found_held", m_found, e_found);
        chk("timeout_held", m_timeout, e_to);
        @(negedge clk);
        chk("still_idle", {m_busy, m_reset_nos}, 0);
        chk("init_after", m_init_state, iv);
    endtask

    initial begin
        ifa.start = 1'b0; ifa.init_vec = '0;
        ifb.start = 1'b0; ifb.init_vec = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        sel = 1'b0;
        check_cleared("reset_a");
        sel = 1'b1;
        check_cleared("reset_b");
        sel = 1'b0;
        rst = 1'b0;

        // Fixed point: k=1, p=1, 1+3+2+1 cycles.
        mode_a = 0;
        run(8'hA5, 1, 0, 1, 1, 7, 0);

        // Transient 2 into cycle 3: k=3, p=3, 1+9+6+1 cycles.
        mode_a = 1;
        run(8'h10, 1, 0, 3, 3, 17, 0);

        // MAX_STEPS=5, 64-long cycle after transient 10: timeout at k=5, 1+15+1 cycles.
        sel = 1'b1;
        mode_b = 2;
        run(8'h00, 0, 1, 5, 0, 17, 0);
        sel = 1'b0;

        // Reset during RUN_B of the cycle-3 case.
        @(negedge clk);
        drive_start(8'h10);
        @(negedge clk);
        drop_start();
        chk("rst_case_load", m_reset_nos, 1);
        @(negedge clk);
        @(negedge clk);
        chk("rst_case_run_b", {m_s0, m_s1, m_busy}, 3'b111);
        rst = 1'b1;
        @(negedge clk);
        check_cleared("mid_rst");
        rst = 1'b0;
        run(8'h10, 1, 0, 3, 3, 17, 0);

        // Starts while busy and in the done cycle are ignored.
        run(8'h10, 1, 0, 3, 3, 17, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
